// File: rtl/pipe_hazard_unit.sv
// Pipeline hazard controller: merges stall requests, memory-ready and flush
// requests into per-stage stall/flush vectors, with deferred flushes and a stall watchdog.
module pipe_hazard_unit #(
    parameter int NSTAGE    = 7,
    parameter int NREQ      = 4,
    parameter int FLUSH_CYC = 1,
    parameter int WDOG_W    = 8,
    localparam int SW       = $clog2(NSTAGE)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy_i,
    input  logic [NREQ-1:0]      req_i,
    input  logic [NREQ*SW-1:0]   req_stage_i,
    input  logic                 flush_i,
    input  logic [SW-1:0]        flush_stage_i,
    output logic [NSTAGE-1:0]    stall_o,
    output logic [NSTAGE-1:0]    flush_o,
    output logic                 flush_ack_o,
    output logic                 flush_pend_o,
    output logic [31:0]          stall_cnt_o,
    output logic                 wdog_o
);

    localparam int CW = $clog2(FLUSH_CYC + 1);
    localparam logic [CW-1:0] BUB_INIT = CW'(FLUSH_CYC - 1);
    localparam logic [SW-1:0] LAST = SW'(NSTAGE - 1);
    localparam logic [WDOG_W-1:0] WMAX = '1;

    typedef enum logic {IDLE, FLUSH} state_t;

    state_t            state, state_n;
    logic [CW-1:0]     bub_cnt, bub_cnt_n;
    logic [SW-1:0]     fl_stage, fl_stage_n;
    logic              pend_valid, pend_valid_n;
    logic [SW-1:0]     pend_stage, pend_stage_n;
    logic [31:0]       stall_cnt;
    logic [WDOG_W-1:0] wcnt, wcnt_n;
    logic              wdog;

    logic [SW-1:0]     smax, fi, fp, f, merged;
    logic              smax_v;
    logic [NSTAGE-1:0] base;

    function automatic logic [NSTAGE-1:0] upto(input logic [SW-1:0] s);
        logic [NSTAGE-1:0] m;
        for (int i = 0; i < NSTAGE; i++) m[i] = (i <= int'(s));
        return m;
    endfunction

    // Deepest active requester, with out-of-range indices clamped to the last stage.
    always_comb begin
        smax   = '0;
        smax_v = 1'b0;
        for (int j = 0; j < NREQ; j++) begin
            if (req_i[j]) begin
                smax_v = 1'b1;
                if (int'(req_stage_i[j*SW +: SW]) >= NSTAGE) begin
                    if (LAST > smax) smax = LAST;
                end else if (req_stage_i[j*SW +: SW] > smax) begin
                    smax = req_stage_i[j*SW +: SW];
                end
            end
        end
        base = smax_v ? upto(smax) : '0;
    end

    always_comb begin
        fi     = flush_i ? flush_stage_i : '0;
        fp     = pend_valid ? pend_stage : '0;
        f      = (fi > fp) ? fi : fp;
        merged = (pend_valid && pend_stage > flush_stage_i) ? pend_stage : flush_stage_i;
    end

    // Next-state and outputs; a flush overrides stalls of the stages it kills.
    always_comb begin
        state_n      = state;
        bub_cnt_n    = bub_cnt;
        fl_stage_n   = fl_stage;
        pend_valid_n = pend_valid;
        pend_stage_n = pend_stage;
        stall_o      = base;
        flush_o      = '0;
        flush_ack_o  = 1'b0;
        if (!rdy_i) begin
            stall_o = '1;
            if (flush_i) begin
                pend_valid_n = 1'b1;
                pend_stage_n = merged;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (flush_i || pend_valid) begin
                        if (!smax_v || smax <= f) begin
                            flush_ack_o  = 1'b1;
                            pend_valid_n = 1'b0;
                            pend_stage_n = '0;
                            if (f != '0) begin
                                flush_o = upto(f) & ~NSTAGE'(1);
                                stall_o = base & ~upto(f);
                                if (FLUSH_CYC > 1) begin
                                    state_n    = FLUSH;
                                    bub_cnt_n  = BUB_INIT;
                                    fl_stage_n = f;
                                end
                            end
                        end else begin
                            pend_valid_n = 1'b1;
                            pend_stage_n = f;
                        end
                    end
                end
                FLUSH: begin
                    if (flush_i) begin
                        pend_valid_n = 1'b1;
                        pend_stage_n = merged;
                    end
                    if (!(smax_v && smax > fl_stage)) begin
                        flush_o   = upto(fl_stage) & ~NSTAGE'(1);
                        stall_o   = base & ~upto(fl_stage);
                        bub_cnt_n = bub_cnt - CW'(1);
                        if (bub_cnt == CW'(1)) state_n = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
        if (rst) begin
            stall_o     = '0;
            flush_o     = '0;
            flush_ack_o = 1'b0;
        end
    end

    // Watchdog counts consecutive stalled cycles, saturating at its maximum.
    always_comb begin
        wcnt_n = wcnt;
        if (rdy_i && stall_o != '0) wcnt_n = (wcnt == WMAX) ? wcnt : wcnt + 1'b1;
        else if (stall_o == '0)     wcnt_n = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            bub_cnt    <= '0;
            fl_stage   <= '0;
            pend_valid <= 1'b0;
            pend_stage <= '0;
            stall_cnt  <= '0;
            wcnt       <= '0;
            wdog       <= 1'b0;
        end else begin
            state      <= state_n;
            bub_cnt    <= bub_cnt_n;
            fl_stage   <= fl_stage_n;
            pend_valid <= pend_valid_n;
            pend_stage <= pend_stage_n;
            if (rdy_i && stall_o != '0) stall_cnt <= stall_cnt + 32'd1;
            wcnt <= wcnt_n;
            if (wcnt_n == WMAX) wdog <= 1'b1;
        end
    end

    assign flush_pend_o = pend_valid;
    assign stall_cnt_o  = stall_cnt;
    assign wdog_o       = wdog;

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Directed bench for pipe_hazard_unit: default instance plus a FLUSH_CYC=3 /
// WDOG_W=4 instance driven from the same inputs.
module tb_pipe_hazard_unit;

    logic        clk = 1'b0;
    logic        rst, rdy_i, flush_i;
    logic [3:0]  req_i;
    logic [11:0] req_stage_i;
    logic [2:0]  flush_stage_i;

    logic [6:0]  stall_o, flush_o, stall3, flush3;
    logic        ack, pend, wdog, ack3, pend3, wdog3;
    logic [31:0] cnt, cnt3;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    pipe_hazard_unit dut (
        .clk(clk), .rst(rst), .rdy_i(rdy_i), .req_i(req_i), .req_stage_i(req_stage_i),
        .flush_i(flush_i), .flush_stage_i(flush_stage_i), .stall_o(stall_o), .flush_o(flush_o),
        .flush_ack_o(ack), .flush_pend_o(pend), .stall_cnt_o(cnt), .wdog_o(wdog)
    );

    pipe_hazard_unit #(.FLUSH_CYC(3), .WDOG_W(4)) dut3 (
        .clk(clk), .rst(rst), .rdy_i(rdy_i), .req_i(req_i), .req_stage_i(req_stage_i),
        .flush_i(flush_i), .flush_stage_i(flush_stage_i), .stall_o(stall3), .flush_o(flush3),
        .flush_ack_o(ack3), .flush_pend_o(pend3), .stall_cnt_o(cnt3), .wdog_o(wdog3)
    );

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic r, input logic [3:0] rq, input logic [11:0] rs,
                                  input logic fl, input logic [2:0] fs);
        rdy_i = r; req_i = rq; req_stage_i = rs; flush_i = fl; flush_stage_i = fs;
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        apply_stimulus(1'b1, 4'b0, 12'h0, 1'b0, 3'd0);
        next_cycle();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL timeout observed=running expected=finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst = 1'b1;
        apply_stimulus(1'b1, 4'b0, 12'h0, 1'b0, 3'd0);
        next_cycle();
        apply_stimulus(1'b1, 4'b0001, {3'd0, 3'd0, 3'd0, 3'd3}, 1'b1, 3'd4);
        check_output("rst_stall", 32'(stall_o), 32'h0);
        check_output("rst_flush", 32'(flush_o), 32'h0);
        check_output("rst_ack", 32'(ack), 32'h0);
        next_cycle();
        rst = 1'b0;
        check_output("rst_cnt", cnt, 32'h0);
        check_output("rst_pend", 32'(pend), 32'h0);
        check_output("rst_wdog", 32'(wdog), 32'h0);

        // Base stall from the deepest requester
        apply_stimulus(1'b1, 4'b0011, {3'd0, 3'd0, 3'd5, 3'd3}, 1'b0, 3'd0);
        check_output("base_35", 32'(stall_o), 32'b0111111);
        check_output("base_35_flush", 32'(flush_o), 32'h0);
        next_cycle();
        check_output("cnt_1", cnt, 32'd1);
        apply_stimulus(1'b1, 4'b0001, {3'd0, 3'd0, 3'd5, 3'd3}, 1'b0, 3'd0);
        check_output("base_3", 32'(stall_o), 32'b0001111);
        next_cycle();
        check_output("cnt_2", cnt, 32'd2);
        apply_stimulus(1'b1, 4'b0100, {3'd0, 3'd7, 3'd0, 3'd0}, 1'b0, 3'd0);
        check_output("clamp_7", 32'(stall_o), 32'b1111111);
        next_cycle();
        check_output("cnt_3", cnt, 32'd3);
        apply_stimulus(1'b1, 4'b0000, 12'h0, 1'b0, 3'd0);
        check_output("no_req", 32'(stall_o), 32'h0);
        next_cycle();
        check_output("cnt_hold_idle", cnt, 32'd3);

        // Memory not ready freezes everything and defers the flush
        apply_stimulus(1'b0, 4'b0001, {3'd0, 3'd0, 3'd0, 3'd2}, 1'b1, 3'd4);
        check_output("nrdy_stall", 32'(stall_o), 32'b1111111);
        check_output("nrdy_flush", 32'(flush_o), 32'h0);
        check_output("nrdy_ack", 32'(ack), 32'h0);
        next_cycle();
        check_output("nrdy_pend", 32'(pend), 32'h1);
        check_output("nrdy_cnt_hold", cnt, 32'd3);
        apply_stimulus(1'b1, 4'b0001, {3'd0, 3'd0, 3'd0, 3'd2}, 1'b0, 3'd0);
        check_output("rdy_ack", 32'(ack), 32'h1);
        check_output("rdy_flush", 32'(flush_o), 32'b0011110);
        check_output("rdy_stall", 32'(stall_o), 32'h0);
        next_cycle();
        check_output("rdy_pend_clr", 32'(pend), 32'h0);
        check_output("rdy_cnt", cnt, 32'd3);

        // Deferred flush while a deeper stall is held for three cycles
        apply_stimulus(1'b1, 4'b0001, {3'd0, 3'd0, 3'd0, 3'd5}, 1'b1, 3'd2);
        check_output("defer_ack0", 32'(ack), 32'h0);
        check_output("defer_stall0", 32'(stall_o), 32'b0111111);
        next_cycle();
        for (int c = 1; c <= 2; c++) begin
            apply_stimulus(1'b1, 4'b0001, {3'd0, 3'd0, 3'd0, 3'd5}, 1'b0, 3'd0);
            check_output($sformatf("defer_pend%0d", c), 32'(pend), 32'h1);
            check_output($sformatf("defer_ack%0d", c), 32'(ack), 32'h0);
            next_cycle();
        end
        apply_stimulus(1'b1, 4'b0000, 12'h0, 1'b0, 3'd0);
        check_output("defer_pend3", 32'(pend), 32'h1);
        check_output("defer_ack3", 32'(ack), 32'h1);
        check_output("defer_flush3", 32'(flush_o), 32'b0000110);
        check_output("defer_stall3", 32'(stall_o), 32'h0);
        next_cycle();
        check_output("defer_pend_clr", 32'(pend), 32'h0);
        check_output("defer_cnt", cnt, 32'd6);

        // Two blocked flushes merge into one ack at the deeper stage
        apply_stimulus(1'b1, 4'b0001, {3'd0, 3'd0, 3'd0, 3'd6}, 1'b1, 3'd2);
        next_cycle();
        apply_stimulus(1'b1, 4'b0001, {3'd0, 3'd0, 3'd0, 3'd6}, 1'b1, 3'd4);
        check_output("merge_ack_blk", 32'(ack), 32'h0);
        next_cycle();
        apply_stimulus(1'b1, 4'b0000, 12'h0, 1'b0, 3'd0);
        check_output("merge_ack", 32'(ack), 32'h1);
        check_output("merge_flush", 32'(flush_o), 32'b0011110);
        next_cycle();
        check_output("merge_pend_clr", 32'(pend), 32'h0);
        check_output("merge_single_ack", 32'(ack), 32'h0);

        // Three-cycle bubble with a one-cycle pause
        do_reset();
        apply_stimulus(1'b1, 4'b0000, 12'h0, 1'b1, 3'd3);
        check_output("bub_ack", 32'(ack3), 32'h1);
        check_output("bub_c0", 32'(flush3), 32'b0001110);
        next_cycle();
        apply_stimulus(1'b1, 4'b0001, {3'd0, 3'd0, 3'd0, 3'd6}, 1'b0, 3'd0);
        check_output("bub_c1_pause", 32'(flush3), 32'h0);
        check_output("bub_c1_stall", 32'(stall3), 32'b1111111);
        next_cycle();
        apply_stimulus(1'b1, 4'b0000, 12'h0, 1'b0, 3'd0);
        check_output("bub_c2", 32'(flush3), 32'b0001110);
        next_cycle();
        check_output("bub_c3", 32'(flush3), 32'b0001110);
        next_cycle();
        check_output("bub_c4_done", 32'(flush3), 32'h0);

        // Watchdog trips after 15 consecutive stalled cycles
        do_reset();
        apply_stimulus(1'b1, 4'b0001, {3'd0, 3'd0, 3'd0, 3'd1}, 1'b0, 3'd0);
        for (int c = 0; c < 14; c++) next_cycle();
        check_output("wdog_14", 32'(wdog3), 32'h0);
        next_cycle();
        check_output("wdog_15", 32'(wdog3), 32'h1);
        check_output("wdog_w8", 32'(wdog), 32'h0);
        apply_stimulus(1'b1, 4'b0000, 12'h0, 1'b0, 3'd0);
        next_cycle();
        next_cycle();
        check_output("wdog_sticky", 32'(wdog3), 32'h1);

        // Reset in the middle of a bubble
        do_reset();
        apply_stimulus(1'b1, 4'b0000, 12'h0, 1'b1, 3'd5);
        check_output("midrst_ack", 32'(ack3), 32'h1);
        next_cycle();
        rst = 1'b1;
        apply_stimulus(1'b1, 4'b0001, {3'd0, 3'd0, 3'd0, 3'd2}, 1'b1, 3'd4);
        check_output("midrst_flush", 32'(flush3), 32'h0);
        check_output("midrst_stall", 32'(stall3), 32'h0);
        next_cycle();
        rst = 1'b0;
        apply_stimulus(1'b1, 4'b0000, 12'h0, 1'b0, 3'd0);
        check_output("postrst_flush", 32'(flush3), 32'h0);
        check_output("postrst_stall", 32'(stall3), 32'h0);
        check_output("postrst_pend", 32'(pend3), 32'h0);
        check_output("postrst_cnt", cnt3, 32'h0);
        check_output("postrst_wdog", 32'(wdog3), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
